// File: rtl/seq_pkg.sv
// Shared definitions for the program-run sequencer.
//   state_e           : sequencer FSM states
//   *_DEF             : default widths and result grouping
//   cnt_width()       : bit width needed to count 0..n-1 (minimum 1)
package seq_pkg;

  localparam int unsigned ADDR_W_DEF       = 16;
  localparam int unsigned INSTR_W_DEF      = 3;
  localparam int unsigned DATA_W_DEF       = 13;
  localparam int unsigned RESULT_EVERY_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_group_counter.sv
// Counts fetched-instruction pulses modulo RESULT_EVERY.
//   clk, rst      : clock, asynchronous active-high reset
//   clear_i       : restart counting (new run)
//   valid_i       : an instruction reached the control unit this cycle
//   last_i        : that instruction is the final one of the program
//   group_done_o  : valid_i completes a full group of RESULT_EVERY
//   partial_o     : valid_i is the final instruction of a short group
module result_group_counter
  import seq_pkg::*;
#(
  parameter int unsigned RESULT_EVERY = RESULT_EVERY_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic valid_i,
  input  logic last_i,
  output logic group_done_o,
  output logic partial_o
);

  localparam int unsigned CW = cnt_width(RESULT_EVERY);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_end;

  assign at_end       = (cnt_q == CW'(RESULT_EVERY - 1));
  assign group_done_o = valid_i && at_end;
  assign partial_o    = valid_i && last_i && !at_end;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (valid_i) begin
      cnt_d = (at_end || last_i) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/prog_run_sequencer.sv
// Program load/run sequencer owning the instruction SRAM, the control unit
// input and the data SRAM write port.
//   Load side : load_valid/load_instr/load_ready, load_clear, prog_len
//   Run side  : start, busy, done, res_count
//   imem_*    : instruction SRAM port (read data has 1-cycle latency)
//   cu_*      : control unit instruction in / result out
//   dmem_*    : data SRAM write port
module prog_run_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned INSTR_W      = INSTR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned RESULT_EVERY = RESULT_EVERY_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_instr,
  output logic               load_ready,
  input  logic               load_clear,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  prog_len,
  output logic [ADDR_W-1:0]  res_count,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_wr,
  output logic               imem_rd,
  output logic [INSTR_W-1:0] imem_wdata,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] cu_in,
  output logic               cu_valid,
  input  logic [DATA_W-1:0]  cu_out,
  output logic [ADDR_W-1:0]  dmem_addr,
  output logic               dmem_wr,
  output logic [DATA_W-1:0]  dmem_wdata
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   prog_len_q, prog_len_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   res_count_q;
  logic                drain_q, drain_d;
  logic                cu_valid_q, cu_last_q, wr_pend_q;
  logic [INSTR_W-1:0]  cu_hold_q;
  logic                run_start, issue_last;
  logic                group_done, partial;

  assign issue_last = (state_q == RUN) && (rd_ptr_q == prog_len_q - ADDR_W'(1));

  always_comb begin
    state_d    = state_q;
    prog_len_d = prog_len_q;
    rd_ptr_d   = rd_ptr_q;
    drain_d    = drain_q;
    run_start  = 1'b0;
    load_ready = 1'b0;
    imem_wr    = 1'b0;
    imem_rd    = 1'b0;
    imem_addr  = '0;
    imem_wdata = '0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Gated by rst so no write enable escapes while reset is held.
        if (!rst) begin
          load_ready = (prog_len_q != '1);
          if (load_clear) begin
            prog_len_d = '0;
          end else if (load_valid && load_ready) begin
            imem_wr    = 1'b1;
            imem_addr  = prog_len_q;
            imem_wdata = load_instr;
            prog_len_d = prog_len_q + ADDR_W'(1);
          end else if (start) begin
            run_start = 1'b1;
            rd_ptr_d  = '0;
            state_d   = (prog_len_q == '0) ? DONE : RUN;
          end
        end
      end
      RUN: begin
        imem_rd   = 1'b1;
        imem_addr = rd_ptr_q;
        rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
        if (issue_last) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = DONE;
          drain_d = 1'b0;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  result_group_counter #(.RESULT_EVERY(RESULT_EVERY)) u_group (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (run_start),
    .valid_i     (cu_valid_q),
    .last_i      (cu_last_q),
    .group_done_o(group_done),
    .partial_o   (partial)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      prog_len_q  <= '0;
      rd_ptr_q    <= '0;
      res_count_q <= '0;
      drain_q     <= 1'b0;
      cu_valid_q  <= 1'b0;
      cu_last_q   <= 1'b0;
      wr_pend_q   <= 1'b0;
      cu_hold_q   <= '0;
    end else begin
      state_q    <= state_d;
      prog_len_q <= prog_len_d;
      rd_ptr_q   <= rd_ptr_d;
      drain_q    <= drain_d;
      // Read data arrives one cycle after issue, so valid/last trail the fetch.
      cu_valid_q <= (state_q == RUN);
      cu_last_q  <= issue_last;
      wr_pend_q  <= group_done || partial;
      if (cu_valid_q) cu_hold_q <= imem_rdata;
      if (run_start)      res_count_q <= '0;
      else if (wr_pend_q) res_count_q <= res_count_q + ADDR_W'(1);
    end
  end

  assign cu_valid   = cu_valid_q;
  assign cu_in      = cu_valid_q ? imem_rdata : cu_hold_q;
  assign dmem_wr    = wr_pend_q;
  assign dmem_addr  = res_count_q;
  assign dmem_wdata = wr_pend_q ? cu_out : '0;
  assign busy       = (state_q != IDLE);
  assign prog_len   = prog_len_q;
  assign res_count  = res_count_q;

endmodule

// File: doc/prog_run_sequencer.md
Name: prog_run_sequencer

Overview:
Sequencer that owns the instruction SRAM, the control unit input and the data SRAM write port.
- Load phase: accepts a stream of 3-bit instructions and writes them to consecutive instruction SRAM addresses from 0.
- Run phase: fetches the stored program one instruction per cycle into the control unit, then writes the 13-bit control unit result into the data SRAM once every RESULT_EVERY instructions.
- Replaces the ad-hoc wr/rd address juggling at the top level. The program is retained after a run, so it can be rerun.

Parameters:
ADDR_W, 16, instruction/data SRAM address width
INSTR_W, 3, instruction width
DATA_W, 13, control unit result / data SRAM word width
RESULT_EVERY, 2, instructions per stored result (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
load_valid  in  1  instruction offered for loading
load_instr  in  INSTR_W  instruction to load
load_ready  out  1  sequencer can accept a load this cycle
load_clear  in  1  discard stored program (IDLE only)
start  in  1  begin a run of the stored program
busy  out  1  high in RUN/DRAIN/DONE
done  out  1  one-cycle pulse at run end
prog_len  out  ADDR_W  number of stored instructions
res_count  out  ADDR_W  results written in current/last run
imem_addr  out  ADDR_W  instruction SRAM address
imem_wr  out  1  instruction SRAM write enable
imem_rd  out  1  instruction SRAM read enable
imem_wdata  out  INSTR_W  instruction SRAM write data
imem_rdata  in  INSTR_W  instruction SRAM read data (1-cycle latency)
cu_in  out  INSTR_W  control unit instruction
cu_valid  out  1  cu_in carries a fetched instruction
cu_out  in  DATA_W  control unit result
dmem_addr  out  ADDR_W  data SRAM address
dmem_wr  out  1  data SRAM write enable
dmem_wdata  out  DATA_W  data SRAM write data

Behaviour:
- Reset (asynchronous, any state): state=IDLE, prog_len=0, res_count=0, all enables=0, all addresses/data outputs=0, done=0, busy=0. Memory contents are untouched but unreachable because prog_len=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - load_ready = (prog_len != 2^ADDR_W-1).
  - load_valid&load_ready: imem_wr=1, imem_addr=prog_len, imem_wdata=load_instr, combinational the same cycle; prog_len++ at the edge.
  - Load when full (load_ready=0): ignored, no write.
  - Priority when several inputs are high in the same cycle: load_clear > load > start. load_clear sets prog_len=0.
  - start with prog_len>0: RUN; rd_ptr=0, fed count=0, res_count=0, dmem pointer=0.
  - start with prog_len==0: DONE directly, no memory traffic.
- RUN, cycle k counted from 0 at RUN entry, k = 0..L-1 where L=prog_len:
  - imem_rd=1, imem_addr=k.
  - After issuing L-1, go to DRAIN.
  - load_ready=0; load_valid, start and load_clear are ignored.
- cu_valid/cu_in: cycle k+1 has cu_valid=1 and cu_in=imem_rdata, i.e. instruction k. cu_in holds its last value when cu_valid=0.
- Result write:
  - Trigger: the cycle after the cu_valid that completes a group of RESULT_EVERY instructions, and also the cycle after the final cu_valid when L mod RESULT_EVERY != 0 (partial group).
  - Action: dmem_wr=1, dmem_addr=res_count, dmem_wdata=cu_out sampled that cycle; res_count++.
  - Total writes per run = ceil(L/RESULT_EVERY).
  - dmem_addr wraps modulo 2^ADDR_W.
- DRAIN: two cycles, cycle L and cycle L+1. These carry the last cu_valid and the final write.
- DONE:
  - One cycle at cycle L+2 with done=1; then IDLE.
  - For the prog_len==0 case, DONE is the cycle after start.
- Mutual exclusion: imem_wr and imem_rd are never both high.
- busy: high in RUN, DRAIN and DONE.
- Reset during RUN/DRAIN: abort immediately, with no further SRAM enables and no done pulse.

Decomposition:
- Shared package seq_pkg:
  - state enum: IDLE, RUN, DRAIN, DONE
  - ADDR_W/INSTR_W/DATA_W defaults
  - RESULT_EVERY default
- One sub-module, result_group_counter. It counts cu_valid pulses modulo RESULT_EVERY and flags group-complete / final-partial.

Test Plan:
- Load 1,2,1,0 (4 cycles, imem_wr addrs 0..3), start, RESULT_EVERY=2 -> imem_rd addrs 0..3 at run cycles 0..3; cu_in 1,2,1,0 at cycles 1..4; dmem_wr at cycles 3 and 5 to addrs 0 and 1; done at cycle 6; res_count=2.
- Same program, RESULT_EVERY=3 -> writes at cycle 4 (addr 0) and cycle 5 (addr 1, partial group); res_count=2.
- start with prog_len=0 -> done pulse next cycle, no imem_rd/dmem_wr, busy high one cycle.
- load_valid held during RUN, and start re-asserted mid-run -> no imem_wr, prog_len unchanged, run completes normally; second start after done reruns with identical outputs.
- Fill to prog_len=65535 -> load_ready=0, further load_valid ignored; load_clear -> prog_len=0, load_ready=1.
- Assert rst at run cycle 2 -> all outputs 0 immediately, state IDLE, prog_len=0, no done pulse.
